// File: rtl/regfile_sb.sv
// ID-stage register file with a pending-write scoreboard and a sequenced clear engine.
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_sb #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned DEBUG_TAPS = 0
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr_a,
  output logic [DW-1:0] rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b,
  output logic          busy_a,
  output logic          busy_b,
  input  logic          sb_set,
  input  logic [AW-1:0] sb_addr,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic [DW-1:0] dbg_r2,
  output logic [DW-1:0] dbg_r3,
  output logic [DW-1:0] dbg_r4,
  output logic [DW-1:0] dbg_r5,
  output logic [DW-1:0] dbg_r6,
  output logic [DW-1:0] dbg_r7
);

  localparam int unsigned   DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [AW-1:0]     clr_cnt;
  logic [DW-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]  sb;
  logic              idle;
  logic              wr_ok;

  assign idle     = (state == IDLE);
  assign wr_ok    = idle && wr_en && (wr_addr != '0);
  assign clr_busy = (state == CLEAR);

  // Clear sequencer: counter walks 1..DEPTH-1, entry 0 never needs zeroing.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_cnt <= AW'(1);
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Storage array; producer writes are dropped while the clear engine owns the array.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: the set is applied after the clear so a newer producer wins.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sb <= '0;
    end else if (idle) begin
      if (clr_req) begin
        sb <= '0;
      end else begin
        if (wr_ok) begin
          sb[wr_addr] <= 1'b0;
        end
        if (sb_set && (sb_addr != '0)) begin
          sb[sb_addr] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data_a = '0;
    busy_a    = 1'b0;
    if (rd_addr_a != '0) begin
      rd_data_a = mem[rd_addr_a];
      busy_a    = clr_busy || sb[rd_addr_a];
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
        busy_a    = sb_set && (sb_addr == rd_addr_a);
      end
`endif
    end
  end

  always_comb begin
    rd_data_b = '0;
    busy_b    = 1'b0;
    if (rd_addr_b != '0) begin
      rd_data_b = mem[rd_addr_b];
      busy_b    = clr_busy || sb[rd_addr_b];
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
        busy_b    = sb_set && (sb_addr == rd_addr_b);
      end
`endif
    end
  end

  // Debug taps exist only when enabled and the file is deep enough to hold r7.
  generate
    if ((DEBUG_TAPS != 0) && (DEPTH > 7)) begin : g_dbg
      assign dbg_r2 = mem[AW'(2)];
      assign dbg_r3 = mem[AW'(3)];
      assign dbg_r4 = mem[AW'(4)];
      assign dbg_r5 = mem[AW'(5)];
      assign dbg_r6 = mem[AW'(6)];
      assign dbg_r7 = mem[AW'(7)];
    end else begin : g_nodbg
      assign dbg_r2 = '0;
      assign dbg_r3 = '0;
      assign dbg_r4 = '0;
      assign dbg_r5 = '0;
      assign dbg_r6 = '0;
      assign dbg_r7 = '0;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a reference model predicts each cycle's outputs into a queue,
// which is popped and compared once the DUT outputs have settled.
module tb_regfile_sb;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          arst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          busy_a, busy_b;
  logic          sb_set;
  logic [AW-1:0] sb_addr;
  logic          clr_req;
  logic          clr_busy;
  logic [DW-1:0] dbg_r2, dbg_r3, dbg_r4, dbg_r5, dbg_r6, dbg_r7;

  always #5 clk = ~clk;

  regfile_sb #(.DW(DW), .AW(AW), .DEBUG_TAPS(1)) dut (
    .clk(clk), .arst(arst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .dbg_r2(dbg_r2), .dbg_r3(dbg_r3), .dbg_r4(dbg_r4),
    .dbg_r5(dbg_r5), .dbg_r6(dbg_r6), .dbg_r7(dbg_r7)
  );

  typedef struct {
    string               tag;
    logic [DW-1:0]       rda;
    logic [DW-1:0]       rdb;
    logic                ba;
    logic                bb;
    logic                cb;
    logic [5:0][DW-1:0]  dbg;
  } exp_t;

  exp_t          exp_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;

  logic [DW-1:0] m_mem [DEPTH];
  logic          m_sb  [DEPTH];
  bit            m_clr;
  int            m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_sb[i]  = 1'b0;
    end
    m_clr = 1'b0;
    m_cnt = 0;
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == '0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (!m_clr && wr_en && (wr_addr == a)) return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
    if (m_clr) return 1'b1;
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en && (wr_addr == a)) return sb_set && (sb_addr == a);
`endif
    return m_sb[a];
  endfunction

  task automatic model_update();
    bit wr_ok;
    if (!arst) begin
      reset_model();
    end else if (!m_clr) begin
      wr_ok = wr_en && (wr_addr != '0);
      if (wr_ok) m_mem[wr_addr] = wr_data;
      if (clr_req) begin
        for (int i = 0; i < DEPTH; i++) m_sb[i] = 1'b0;
        m_clr = 1'b1;
        m_cnt = 1;
      end else begin
        if (wr_ok) m_sb[wr_addr] = 1'b0;
        if (sb_set && (sb_addr != '0)) m_sb[sb_addr] = 1'b1;
      end
    end else begin
      m_mem[m_cnt] = '0;
      if (m_cnt == DEPTH - 1) begin
        m_clr = 1'b0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One cycle: predict, compare settled outputs, then advance the model across the edge.
  task automatic tick(input string tag);
    exp_t e;
    logic [5:0][DW-1:0] got_dbg;
    e.tag = tag;
    e.rda = exp_data(rd_addr_a);
    e.rdb = exp_data(rd_addr_b);
    e.ba  = exp_busy(rd_addr_a);
    e.bb  = exp_busy(rd_addr_b);
    e.cb  = m_clr;
    for (int i = 0; i < 6; i++) e.dbg[i] = m_mem[i + 2];
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    got_dbg = {dbg_r7, dbg_r6, dbg_r5, dbg_r4, dbg_r3, dbg_r2};
    check({e.tag, "/rd_data_a"}, rd_data_a, e.rda);
    check({e.tag, "/rd_data_b"}, rd_data_b, e.rdb);
    check({e.tag, "/busy_a"}, busy_a, e.ba);
    check({e.tag, "/busy_b"}, busy_b, e.bb);
    check({e.tag, "/clr_busy"}, clr_busy, e.cb);
    for (int i = 0; i < 6; i++) check({e.tag, "/dbg"}, got_dbg[i], e.dbg[i]);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_en = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    int nbusy;
    arst = 1'b0;
    quiet();
    wr_addr = '0; wr_data = '0; sb_addr = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    reset_model();
    @(negedge clk);
    rd_addr_a = 5'd5; rd_addr_b = 5'd31;
    tick("reset");
    tick("reset");
    arst = 1'b1;

    // Basic write/read
    write(5'd5, 32'hDEADBEEF); rd_addr_a = 5'd5; rd_addr_b = 5'd0;
    tick("wr_r5");
    quiet();
    #1 check("r5_readback", rd_data_a, 32'hDEADBEEF);
    check("r0_read_b", rd_data_b, 32'h0);
    tick("rd_r5");

    // r0 immutability
    write(5'd0, 32'h12345678); rd_addr_a = 5'd0;
    tick("wr_r0");
    quiet();
    #1 check("r0_data", rd_data_a, 32'h0);
    check("r0_busy", busy_a, 1'b0);
    tick("rd_r0");

    // Scoreboard set, clear by write, set-wins collision
    sb_set = 1'b1; sb_addr = 5'd9; rd_addr_a = 5'd9;
    tick("sb_set9");
    quiet();
    #1 check("sb9_busy", busy_a, 1'b1);
    tick("sb9_hold");
    write(5'd9, 32'h55);
    tick("wr_r9");
    quiet();
    #1 check("sb9_cleared", busy_a, 1'b0);
    check("r9_data", rd_data_a, 32'h55);
    tick("rd_r9");
    write(5'd9, 32'h66); sb_set = 1'b1; sb_addr = 5'd9;
    tick("set_wr_same");
    quiet();
    #1 check("set_wins", busy_a, 1'b1);
    check("r9_new", rd_data_a, 32'h66);
    tick("rd_r9b");
    write(5'd9, 32'h77); sb_set = 1'b1; sb_addr = 5'd10; rd_addr_b = 5'd10;
    tick("set_wr_diff");
    quiet();
    #1 check("diff_clr9", busy_a, 1'b0);
    check("diff_set10", busy_b, 1'b1);
    tick("rd_diff");

    // Same-cycle write/read on port B
    write(5'd7, 32'h1111);
    tick("wr_r7_old");
    write(5'd7, 32'hA5A5A5A5); rd_addr_b = 5'd7;
`ifdef REGFILE_SB_BYPASS_EN
    #1 check("bypass_same", rd_data_b, 32'hA5A5A5A5);
`else
    #1 check("nobypass_old", rd_data_b, 32'h1111);
`endif
    tick("wr_r7_new");
    quiet();
    #1 check("r7_next", rd_data_b, 32'hA5A5A5A5);
    tick("rd_r7");

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = AW'($urandom);
      wr_data   = $urandom;
      sb_set    = ($urandom_range(0, 2) == 0);
      sb_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
      rd_addr_b = ($urandom_range(0, 2) == 0) ? sb_addr : AW'($urandom);
      tick("rand");
    end
    quiet();

    // Fill with index values, then sequenced clear
    for (int i = 1; i < DEPTH; i++) begin
      write(AW'(i), DW'(i)); rd_addr_a = AW'(i);
      tick("fill");
    end
    quiet();
    sb_set = 1'b1; sb_addr = 5'd12;
    tick("pre_clr_sb");
    quiet();
    clr_req = 1'b1;
    tick("clr_start");
    quiet();
    nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      rd_addr_a = AW'($urandom_range(1, DEPTH - 1));
      rd_addr_b = AW'(c);
      wr_en   = (c == 5);  wr_addr = 5'd3; wr_data = 32'hFFFF;
      sb_set  = (c == 7);  sb_addr = 5'd4;
      clr_req = (c == 12);
      #1 if (clr_busy) nbusy++;
      if (c == 20) check("clr_force_busy", busy_a, 1'b1);
      tick("clearing");
    end
    quiet();
    check("clr_cycles", nbusy, 31);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(DEPTH - 1 - i);
      #1 check("post_clr_zero", rd_data_a, 32'h0);
      check("post_clr_sb", busy_a, 1'b0);
      tick("post_clr");
    end

    // Reset during clear
    for (int i = 1; i < 8; i++) begin
      write(AW'(i), 32'hC0DE0000 | DW'(i));
      tick("refill");
    end
    quiet();
    clr_req = 1'b1;
    tick("clr2_start");
    quiet();
    rd_addr_a = 5'd20; rd_addr_b = 5'd2;
    for (int c = 1; c < 10; c++) tick("clr2_run");
    arst = 1'b0;
    #1 check("rst_mid_clr_busy", clr_busy, 1'b0);
    check("rst_mid_clr_r2", rd_data_b, 32'h0);
    reset_model();
    tick("rst_mid");
    tick("rst_mid");
    arst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(i);
      tick("post_rst");
    end
    clr_req = 1'b1;
    tick("clr3_start");
    quiet();
    #1 check("clr3_busy", clr_busy, 1'b1);
    for (int c = 0; c < 32; c++) tick("clr3_run");
    check("clr3_done", clr_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
